// File: rtl/board_sector_packer.sv
// board_sector_packer: reads the live board out of the 32-bit cell RAM one
// word at a time and streams it as bytes framed into 512-byte sectors for the
// SD sector writer. The final sector is zero-padded to a full 512 bytes.
module board_sector_packer #(
  parameter int P_PARAM_N = 800,
  parameter int P_PARAM_M = 600,
  parameter int BLOCK_LEN = 32,
  parameter int ADDR_W    = 24,
  parameter int BASE_ADDR = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic [ADDR_W-1:0]    ram_addr,
  output logic                 ram_rden,
  input  logic [BLOCK_LEN-1:0] ram_rdata,
  output logic [7:0]           byte_data,
  output logic                 byte_valid,
  input  logic                 byte_ready,
  output logic                 sector_first,
  output logic                 sector_last,
  output logic [15:0]          sector_idx,
  output logic                 busy,
  output logic                 done
);

  localparam int WORDS = P_PARAM_N * P_PARAM_M / BLOCK_LEN;
  localparam int WC_W  = $clog2(WORDS + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_CAPTURE, S_EMIT, S_PAD, S_FINISH
  } state_t;

  state_t              state_q, state_d;
  logic [WC_W-1:0]     word_cnt_q, word_cnt_d;
  logic [1:0]          byte_cnt_q, byte_cnt_d;
  logic [8:0]          bis_q, bis_d;
  logic [15:0]         sector_idx_q, sector_idx_d;
  logic [31:0]         sreg_q, sreg_d;
  logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
  logic                ram_rden_q, ram_rden_d;
  logic                byte_valid_q, byte_valid_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                accept;

  assign accept = byte_valid_q & byte_ready;

  // Next-state and next-output logic; outputs are derived from the next state
  // so every control output comes straight from a flop.
  always_comb begin
    state_d      = state_q;
    word_cnt_d   = word_cnt_q;
    byte_cnt_d   = byte_cnt_q;
    bis_d        = bis_q;
    sector_idx_d = sector_idx_q;
    sreg_d       = sreg_q;
    ram_addr_d   = ram_addr_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d      = S_READ;
          word_cnt_d   = '0;
          byte_cnt_d   = '0;
          bis_d        = '0;
          sector_idx_d = '0;
        end
      end
      S_READ:    state_d = S_CAPTURE;
      S_CAPTURE: begin
        sreg_d  = ram_rdata[31:0];
        state_d = S_EMIT;
      end
      S_EMIT, S_PAD: begin
        if (accept) begin
          // PAD drains an already-empty shift register, so it emits zeros.
          sreg_d = {sreg_q[23:0], 8'h00};
          bis_d  = bis_q + 9'd1;
          if (bis_q == 9'd511) sector_idx_d = sector_idx_q + 16'd1;
          if (state_q == S_PAD) begin
            if (bis_q == 9'd511) state_d = S_FINISH;
          end else begin
            byte_cnt_d = byte_cnt_q + 2'd1;
            if (byte_cnt_q == 2'd3) begin
              word_cnt_d = word_cnt_q + 1'b1;
              if (word_cnt_d < WC_W'(WORDS)) state_d = S_READ;
              else if (bis_d != 9'd0)        state_d = S_PAD;
              else                           state_d = S_FINISH;
            end
          end
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    ram_rden_d = (state_d == S_READ);
    if (state_d == S_READ) begin
      ram_addr_d = ADDR_W'(BASE_ADDR) + ADDR_W'(word_cnt_d);
    end
    byte_valid_d = (state_d == S_EMIT) || (state_d == S_PAD);
    busy_d       = (state_d == S_READ) || (state_d == S_CAPTURE) ||
                   (state_d == S_EMIT) || (state_d == S_PAD);
    done_d       = (state_d == S_FINISH);
  end

  // State and output registers; reset abandons any dump in flight silently.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      word_cnt_q   <= '0;
      byte_cnt_q   <= '0;
      bis_q        <= '0;
      sector_idx_q <= '0;
      sreg_q       <= '0;
      ram_addr_q   <= '0;
      ram_rden_q   <= 1'b0;
      byte_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      word_cnt_q   <= word_cnt_d;
      byte_cnt_q   <= byte_cnt_d;
      bis_q        <= bis_d;
      sector_idx_q <= sector_idx_d;
      sreg_q       <= sreg_d;
      ram_addr_q   <= ram_addr_d;
      ram_rden_q   <= ram_rden_d;
      byte_valid_q <= byte_valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign ram_addr     = ram_addr_q;
  assign ram_rden     = ram_rden_q;
  assign byte_data    = sreg_q[31:24];
  assign byte_valid   = byte_valid_q;
  assign sector_first = byte_valid_q & (bis_q == 9'd0);
  assign sector_last  = byte_valid_q & (bis_q == 9'd511);
  assign sector_idx   = sector_idx_q;
  assign busy         = busy_q;
  assign done         = done_q;

endmodule

// File: tb/tb_board_sector_packer.sv
// tb_board_sector_packer: directed bench for board_sector_packer.
// dut1: 352x64 board -> 704 words, 2816 data bytes, 6 sectors, 256 pad bytes.
// dut2: 128x32 board -> 128 words, 512 bytes, exactly one sector, no padding.
module tb_board_sector_packer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        start_r = 1'b0;
  logic        ready_r = 1'b0;
  logic        sel = 1'b0;
  logic [31:0] w0 = 32'h0;

  logic        start1, start2, ready1, ready2;
  logic [23:0] addr1, addr2;
  logic        rden1, rden2;
  logic [31:0] rdata1 = 32'h0, rdata2 = 32'h0;
  logic [7:0]  data1, data2;
  logic        valid1, valid2, first1, first2, last1, last2;
  logic [15:0] idx1, idx2;
  logic        busy1, busy2, done1, done2;

  assign start1 = start_r & ~sel;
  assign start2 = start_r &  sel;
  assign ready1 = ready_r & ~sel;
  assign ready2 = ready_r &  sel;

  board_sector_packer #(.P_PARAM_N(352), .P_PARAM_M(64)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .ram_addr(addr1), .ram_rden(rden1),
    .ram_rdata(rdata1), .byte_data(data1), .byte_valid(valid1), .byte_ready(ready1),
    .sector_first(first1), .sector_last(last1), .sector_idx(idx1),
    .busy(busy1), .done(done1));

  board_sector_packer #(.P_PARAM_N(128), .P_PARAM_M(32)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .ram_addr(addr2), .ram_rden(rden2),
    .ram_rdata(rdata2), .byte_data(data2), .byte_valid(valid2), .byte_ready(ready2),
    .sector_first(first2), .sector_last(last2), .sector_idx(idx2),
    .busy(busy2), .done(done2));

  // RAM models: word i holds i, except word 0 which holds w0.
  function automatic logic [31:0] ram_word(input logic [23:0] a);
    return (a == 24'd0) ? w0 : {8'h00, a};
  endfunction

  always @(posedge clk) begin
    if (rden1) rdata1 <= ram_word(addr1);
    if (rden2) rdata2 <= ram_word(addr2);
  end

  logic [7:0]  m_data;
  logic        m_valid, m_first, m_last, m_rden, m_done, m_busy;
  logic [15:0] m_idx;
  logic [23:0] m_addr;
  assign m_data  = sel ? data2  : data1;
  assign m_valid = sel ? valid2 : valid1;
  assign m_first = sel ? first2 : first1;
  assign m_last  = sel ? last2  : last1;
  assign m_idx   = sel ? idx2   : idx1;
  assign m_rden  = sel ? rden2  : rden1;
  assign m_addr  = sel ? addr2  : addr1;
  assign m_done  = sel ? done2  : done1;
  assign m_busy  = sel ? busy2  : busy1;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] exp_byte(input int k, input int tot);
    logic [31:0] w;
    if (k >= tot) return 8'h00;
    w = (k / 4 == 0) ? w0 : 32'(k / 4);
    return 8'(w >> (24 - 8 * (k % 4)));
  endfunction

  int acc_cnt, first_cnt, last_cnt, rden_cnt, done_cnt, bad_cnt, stall_bad;
  int done_cyc, last_acc_cyc;
  int acc_cyc[8];
  logic [7:0]  got[8];
  logic        first0;
  logic [15:0] idx0, last_idx;
  bit finished, aborted;

  task automatic run_dump(input bit s, input bit rnd, input int tot,
                          input int pulse_at, input int abort_at);
    int cyc, k;
    bit prev_stall, pulsed, stop;
    logic [7:0] pd;
    logic pf, pl;
    logic [15:0] pi;
    acc_cnt = 0; first_cnt = 0; last_cnt = 0; rden_cnt = 0; done_cnt = 0;
    bad_cnt = 0; stall_bad = 0; done_cyc = -1; last_acc_cyc = -100;
    last_idx = 16'hffff; first0 = 1'b0; idx0 = 16'hffff;
    for (int i = 0; i < 8; i++) begin got[i] = 8'hxx; acc_cyc[i] = -1; end
    finished = 0; aborted = 0;
    sel = s;
    @(posedge clk); #1; start_r = 1'b1;
    @(posedge clk); #1; start_r = 1'b0;
    cyc = 0; prev_stall = 0; pulsed = 0; stop = 0;
    pd = 8'h0; pf = 1'b0; pl = 1'b0; pi = 16'h0;
    while (!stop) begin
      if (m_rden) begin
        if (m_addr !== 24'(rden_cnt)) bad_cnt++;
        rden_cnt++;
      end
      if (m_done) begin done_cnt++; done_cyc = cyc; finished = 1; stop = 1; end
      if (prev_stall && (!m_valid || m_data !== pd || m_first !== pf ||
                         m_last !== pl || m_idx !== pi)) stall_bad++;
      ready_r = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      prev_stall = 0;
      if (m_valid && !stop) begin
        if (ready_r) begin
          k = acc_cnt;
          if (k < 8) begin got[k] = m_data; acc_cyc[k] = cyc; end
          if (k == 0) begin first0 = m_first; idx0 = m_idx; end
          if (m_data !== exp_byte(k, tot) || m_first !== (k % 512 == 0) ||
              m_last !== (k % 512 == 511) || m_idx !== 16'(k / 512)) bad_cnt++;
          if (m_first) first_cnt++;
          if (m_last) last_cnt++;
          last_idx = m_idx;
          last_acc_cyc = cyc;
          acc_cnt++;
        end else begin
          prev_stall = 1; pd = m_data; pf = m_first; pl = m_last; pi = m_idx;
        end
      end
      start_r = (!pulsed && pulse_at >= 0 && acc_cnt == pulse_at && m_busy);
      if (start_r) pulsed = 1;
      if (abort_at >= 0 && acc_cnt == abort_at) begin rst = 1'b1; aborted = 1; stop = 1; end
      if (cyc >= 20000) stop = 1;
      if (!stop) begin @(posedge clk); #1; end
      cyc++;
    end
    start_r = 1'b0;
  endtask

  initial begin
    int d_seen, v_seen;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", valid1, 0); chk("rst_busy", busy1, 0); chk("rst_done", done1, 0);
    chk("rst_rden", rden1, 0);   chk("rst_addr", addr1, 0); chk("rst_data", data1, 0);
    chk("rst_first", first1, 0); chk("rst_last", last1, 0); chk("rst_idx", idx1, 0);
    rst = 1'b0;

    // Run A: full dump, ready held high, word i = i
    w0 = 32'h0;
    run_dump(0, 0, 2816, -1, -1);
    chk("A_finished", finished, 1);
    chk("A_accepts", acc_cnt, 3072);
    chk("A_first_cnt", first_cnt, 6);
    chk("A_last_cnt", last_cnt, 6);
    chk("A_last_idx", last_idx, 5);
    chk("A_rden_cnt", rden_cnt, 704);
    chk("A_done_cnt", done_cnt, 1);
    chk("A_done_gap", done_cyc - last_acc_cyc, 1);
    chk("A_bytes0_3", {got[0], got[1], got[2], got[3]}, 32'h00000000);
    chk("A_bytes4_7", {got[4], got[5], got[6], got[7]}, 32'h00000001);
    chk("A_throughput", acc_cyc[4] - acc_cyc[0], 6);
    chk("A_stream_bad", bad_cnt, 0);

    // Run B: start the cycle after done, random ready, stray start at byte 100
    w0 = 32'hDEADBEEF;
    run_dump(0, 1, 2816, 100, -1);
    chk("B_finished", finished, 1);
    chk("B_bytes0_3", {got[0], got[1], got[2], got[3]}, 32'hDEADBEEF);
    chk("B_accepts", acc_cnt, 3072);
    chk("B_last_cnt", last_cnt, 6);
    chk("B_rden_cnt", rden_cnt, 704);
    chk("B_stall_bad", stall_bad, 0);
    chk("B_stream_bad", bad_cnt, 0);

    // Run C: reset in the middle of sector 5
    run_dump(0, 1, 2816, -1, 5 * 512 + 37);
    chk("C_aborted", aborted, 1);
    @(posedge clk); #1;
    chk("C_rst_valid", valid1, 0); chk("C_rst_busy", busy1, 0); chk("C_rst_done", done1, 0);
    chk("C_rst_rden", rden1, 0);   chk("C_rst_addr", addr1, 0); chk("C_rst_data", data1, 0);
    chk("C_rst_first", first1, 0); chk("C_rst_idx", idx1, 0);
    rst = 1'b0;
    d_seen = 0; v_seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (done1) d_seen++;
      if (valid1) v_seen++;
    end
    chk("C_no_done", d_seen, 0);
    chk("C_idle_valid", v_seen, 0);

    // Run D: fresh start after abort
    w0 = 32'h01234567;
    run_dump(0, 0, 2816, -1, -1);
    chk("D_first_flag", first0, 1);
    chk("D_first_idx", idx0, 0);
    chk("D_bytes0_3", {got[0], got[1], got[2], got[3]}, 32'h01234567);
    chk("D_accepts", acc_cnt, 3072);
    chk("D_stream_bad", bad_cnt, 0);

    // Run E: exact multiple of a sector, no padding
    w0 = 32'h0;
    run_dump(1, 0, 512, -1, -1);
    chk("E_finished", finished, 1);
    chk("E_accepts", acc_cnt, 512);
    chk("E_first_cnt", first_cnt, 1);
    chk("E_last_cnt", last_cnt, 1);
    chk("E_last_idx", last_idx, 0);
    chk("E_rden_cnt", rden_cnt, 128);
    chk("E_done_gap", done_cyc - last_acc_cyc, 1);
    chk("E_stream_bad", bad_cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
